// File: rtl/btn_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_if
// Description : Button inputs and increment-pulse outputs of the two-channel
//               push-button debouncer (hour and minute set buttons).
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_debounce_if;
    logic hour_btn;
    logic min_btn;
    logic hour_inc;
    logic min_inc;

    // Button source / pulse consumer side
    modport master (
        output hour_btn,
        output min_btn,
        input  hour_inc,
        input  min_inc
    );

    // Debouncer side
    modport slave (
        input  hour_btn,
        input  min_btn,
        output hour_inc,
        output min_inc
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two independent push-button debouncers (hour, min). Each raw
//               button is synchronized, debounced and turned into one-cycle
//               registered increment pulses. Optional auto-repeat while held
//               is enabled by defining the macro BTN_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int CLOCK_RATE  = 1000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 250
) (
    input  wire           clk,
    input  wire           reset,
    btn_debounce_if.slave bus
);

    // Cycle counts derived from the clock rate
    localparam int          c_N_DEB     = CLOCK_RATE * DEBOUNCE_MS / 1000;
    localparam int          c_N_HOLD    = CLOCK_RATE * HOLD_MS / 1000;
    localparam int          c_N_REP     = CLOCK_RATE * REPEAT_MS / 1000;
    localparam logic [15:0] c_DEB_LAST  = 16'(c_N_DEB - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [15:0] c_HOLD_LAST = 16'(c_N_HOLD - 1);
    localparam logic [15:0] c_REP_LAST  = 16'(c_N_REP - 1);
`endif
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    // A count below 2 would allow back-to-back pulses
    if (c_N_DEB < 2 || c_N_HOLD < 2 || c_N_REP < 2) begin : g_param_check
        $error("btn_debounce: derived cycle counts must all be >= 2");
    end

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        DEB_RELEASE = 3'd3,
        REPEAT      = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        DEB_RELEASE = 3'd3
    } state_t;
`endif

    // Bit 0 = hour channel, bit 1 = min channel
    logic [1:0] w_raw;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] w_inc;

    assign w_raw = {bus.min_btn, bus.hour_btn};

    // Two-flop synchronizer in front of all channel logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        state_t      r_state;
        state_t      w_state_nxt;
        logic [15:0] r_cnt;
        logic [15:0] w_cnt_nxt;
        logic [15:0] w_cnt_inc;
        logic        w_pulse;
        logic        r_inc;

        // Counter advance that sticks at full scale instead of wrapping
        assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + 16'd1);

        // State, shared counter and registered increment pulse
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= IDLE;
                r_cnt   <= 16'd0;
                r_inc   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_inc   <= w_pulse;
            end
        end

        // Next-state, counter and pulse decode; one counter serves every state
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_pulse     = 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync[gi]) begin
                        w_state_nxt = DEB_PRESS;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                DEB_PRESS: begin
                    if (!r_sync[gi]) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 16'd0;
                    end else if (r_cnt >= c_DEB_LAST) begin
                        w_state_nxt = HELD;
                        w_cnt_nxt   = 16'd0;
                        w_pulse     = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                HELD: begin
                    if (!r_sync[gi]) begin
                        // The low sample that leaves HELD counts toward release
                        w_state_nxt = DEB_RELEASE;
                        w_cnt_nxt   = 16'd1;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (r_cnt >= c_HOLD_LAST) begin
                        w_state_nxt = REPEAT;
                        w_cnt_nxt   = 16'd0;
                        w_pulse     = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
`endif
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                REPEAT: begin
                    if (!r_sync[gi]) begin
                        w_state_nxt = DEB_RELEASE;
                        w_cnt_nxt   = 16'd1;
                    end else if (r_cnt >= c_REP_LAST) begin
                        w_cnt_nxt   = 16'd0;
                        w_pulse     = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
`endif
                DEB_RELEASE: begin
                    if (r_sync[gi]) begin
                        // Bounce during release: back to held, hold time restarts
                        w_state_nxt = HELD;
                        w_cnt_nxt   = 16'd0;
                    end else if (r_cnt >= c_DEB_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 16'd0;
                end
            endcase
        end

        assign w_inc[gi] = r_inc;
    end

    assign bus.hour_inc = w_inc[0];
    assign bus.min_inc  = w_inc[1];

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce
// Description : Directed self-checking bench for btn_debounce (default
//               parameters: N_DEB=20, N_HOLD=1000, N_REP=250 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

    logic clk = 1'b0;
    logic reset;

    btn_debounce_if bus ();

    btn_debounce #(
        .CLOCK_RATE  (1000),
        .DEBOUNCE_MS (20),
        .HOLD_MS     (1000),
        .REPEAT_MS   (250)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   edge_no = 0;
    int   base = 0;
    int   consec = 0;
    int   hour_q[$];
    int   min_q[$];
    logic prev_h = 1'b0;
    logic prev_m = 1'b0;

    // One clock edge; outputs sampled 1 time unit later and pulses logged
    // relative to the first edge of the current test (edge 0)
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.hour_inc === 1'b1) hour_q.push_back(edge_no - base);
        if (bus.min_inc === 1'b1)  min_q.push_back(edge_no - base);
        if (bus.hour_inc === 1'b1 && prev_h === 1'b1) consec++;
        if (bus.min_inc === 1'b1 && prev_m === 1'b1)  consec++;
        prev_h = bus.hour_inc;
        prev_m = bus.min_inc;
        edge_no++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic begin_test();
        hour_q.delete();
        min_q.delete();
        base = edge_no;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    initial begin
        reset        = 1'b1;
        bus.hour_btn = 1'b0;
        bus.min_btn  = 1'b0;
        steps(3);
        check("reset_hour_inc", {31'd0, bus.hour_inc}, 32'd0);
        check("reset_min_inc",  {31'd0, bus.min_inc},  32'd0);
        reset = 1'b0;
        steps(5);

        // Clean hour press for 100 cycles
        begin_test();
        bus.hour_btn = 1'b1;
        steps(100);
        bus.hour_btn = 1'b0;
        steps(40);
        check("clean_hour_count", hour_q.size(), 1);
        check("clean_hour_edge",  qat(hour_q, 0), 22);
        check("clean_min_count",  min_q.size(), 0);

        // Press bounce: toggling every 3 cycles never debounces
        begin_test();
        for (int i = 0; i < 15; i++) begin
            bus.min_btn = ((i / 3) % 2) == 0;
            step();
        end
        bus.min_btn = 1'b0;
        steps(40);
        check("bounce_min_count",  min_q.size(), 0);
        check("bounce_hour_count", hour_q.size(), 0);

        // Long min hold: auto-repeat behaviour depends on build option
        begin_test();
        bus.min_btn = 1'b1;
        steps(1600);
        bus.min_btn = 1'b0;
        steps(40);
`ifdef BTN_AUTOREPEAT_EN
        check("hold_min_count", min_q.size(), 4);
        check("hold_min_edge0", qat(min_q, 0), 22);
        check("hold_min_edge1", qat(min_q, 1), 1022);
        check("hold_min_edge2", qat(min_q, 2), 1272);
        check("hold_min_edge3", qat(min_q, 3), 1522);
`else
        check("hold_min_count", min_q.size(), 1);
        check("hold_min_edge0", qat(min_q, 0), 22);
`endif

        // Both buttons on the same edge
        begin_test();
        bus.hour_btn = 1'b1;
        bus.min_btn  = 1'b1;
        steps(50);
        bus.hour_btn = 1'b0;
        bus.min_btn  = 1'b0;
        steps(40);
        check("both_hour_count", hour_q.size(), 1);
        check("both_min_count",  min_q.size(), 1);
        check("both_hour_edge",  qat(hour_q, 0), 22);
        check("both_min_edge",   qat(min_q, 0), 22);

        // Release bounce: low 5, high 3, then low 30
        begin_test();
        bus.hour_btn = 1'b1;
        steps(60);
        bus.hour_btn = 1'b0;
        steps(5);
        bus.hour_btn = 1'b1;
        steps(3);
        bus.hour_btn = 1'b0;
        steps(30);
        check("relbounce_count", hour_q.size(), 1);
        check("relbounce_edge",  qat(hour_q, 0), 22);
        // Channel back in IDLE: a fresh press debounces with full latency
        begin_test();
        bus.hour_btn = 1'b1;
        steps(40);
        bus.hour_btn = 1'b0;
        steps(40);
        check("repress_count", hour_q.size(), 1);
        check("repress_edge",  qat(hour_q, 0), 22);

        // Reset while the pulse is high clears it at once, no later pulse
        begin_test();
        bus.hour_btn = 1'b1;
        steps(23);
        check("pulse_live", {31'd0, bus.hour_inc}, 32'd1);
        reset = 1'b1;
        #1;
        check("pulse_killed_hour", {31'd0, bus.hour_inc}, 32'd0);
        bus.hour_btn = 1'b0;
        steps(3);
        reset = 1'b0;
        steps(40);
        check("pulse_reset_count", hour_q.size(), 1);

        // Reset mid-debounce (edges 11..15) with the button held throughout
        begin_test();
        bus.hour_btn = 1'b1;
        steps(11);
        reset = 1'b1;
        #1;
        check("midreset_hour_inc", {31'd0, bus.hour_inc}, 32'd0);
        steps(5);
        reset = 1'b0;
        steps(65);
        bus.hour_btn = 1'b0;
        steps(40);
        check("midreset_count", hour_q.size(), 1);
        check("midreset_edge",  qat(hour_q, 0), 38);
        check("midreset_min",   min_q.size(), 0);

        check("no_consecutive_high", consec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000, clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, required stable time in ms.
REQ-003 SHALL have parameter HOLD_MS, default 1000, press duration in ms before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_MS, default 250, auto-repeat period in ms.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port hour_btn  input  1  raw asynchronous push-button, active high, bouncy.
REQ-008 SHALL have port min_btn  input  1  raw asynchronous push-button, active high, bouncy.
REQ-009 SHALL have port hour_inc  output  1  registered one-cycle increment pulse feeding the LCD clock's hour_inc.
REQ-010 SHALL have port min_inc  output  1  registered one-cycle increment pulse feeding the LCD clock's min_inc.

Function
REQ-011 SHALL derive N_DEB = CLOCK_RATE*DEBOUNCE_MS/1000, N_HOLD = CLOCK_RATE*HOLD_MS/1000 and N_REP = CLOCK_RATE*REPEAT_MS/1000 cycles; each SHALL be >= 2; counters SHALL be 16 bits wide and saturate, never wrap.
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL run two identical, fully independent channels (hour, min); simultaneous activity on both SHALL NOT interact.
REQ-014 SHALL implement per-channel states IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE.
REQ-015 IDLE: synced=1 -> DEB_PRESS with the stability counter cleared.
REQ-016 DEB_PRESS: synced=0 -> IDLE with no pulse; N_DEB consecutive synced=1 samples -> HELD, and the output pulses high for exactly one cycle.
REQ-017 Pulse timing: the output SHALL rise on the (N_DEB+2)th rising clk edge after the edge that first samples the raw button high, assuming no bounce.
REQ-018 HELD: synced=0 -> DEB_RELEASE; N_HOLD cycles after the initial pulse -> REPEAT with a one-cycle pulse.
REQ-019 REPEAT: one-cycle pulse every N_REP cycles while synced=1; synced=0 -> DEB_RELEASE.
REQ-020 DEB_RELEASE: N_DEB consecutive synced=0 samples -> IDLE; synced=1 before that -> HELD with the hold counter restarted and no pulse.
REQ-021 An output SHALL never be high on two consecutive cycles, so the downstream rising-edge detector counts every pulse.

Reset
REQ-022 Asserting reset SHALL immediately force hour_inc=0, min_inc=0, synchronizers=0, both channels to IDLE and all counters to 0.
REQ-023 When reset is asserted mid-pulse or mid-debounce, the block SHALL abandon that activity with no pulse after release.
REQ-024 A button held through reset deassertion SHALL be treated as a new press and produce exactly one debounced pulse.

Configuration
REQ-025 Macro BTN_AUTOREPEAT_EN SHALL control auto-repeat.
REQ-026 With BTN_AUTOREPEAT_EN defined, behaviour SHALL be as in REQ-018 and REQ-019.
REQ-027 Without BTN_AUTOREPEAT_EN, the REPEAT state and hold/repeat counters SHALL be absent; HELD SHALL wait only for release, giving exactly one pulse per debounced press.

Verification
REQ-028 Defaults, hour_btn clean high 100 cycles -> exactly one hour_inc pulse, rising at edge 22 after the first high sample; min_inc stays 0.
REQ-029 min_btn toggling every 3 cycles for 15 cycles, then low -> no min_inc pulse.
REQ-030 min_btn held 1600 cycles, BTN_AUTOREPEAT_EN defined -> min_inc pulses at edges 22, 1022, 1272 and 1522 relative to the first sample; the same stimulus without the macro -> only the pulse at edge 22.
REQ-031 Both buttons pressed on the same edge, held 50 cycles -> hour_inc and min_inc each pulse once, on the same cycle.
REQ-032 Release bounce: button drops low for 5 cycles, returns high for 3, then stays low 30 -> no extra pulse; the channel returns to IDLE.
REQ-033 Reset asserted at cycle 10 of a press, released at cycle 15, with the button still held -> one pulse, N_DEB+2 edges after the first post-reset sample.
